// File: rtl/bram_pkg.sv
// bram_pkg: shared constants, grant encoding and address-width helper for the BRAM port controller
//   DEFAULT_RAM_WIDTH / DEFAULT_RAM_DEPTH : default geometry of the attached single-port RAM
//   grant_t                               : which side won the last write/read conflict
//   addr_w()                              : address width for a given word count
package bram_pkg;
    localparam int DEFAULT_RAM_WIDTH = 16;
    localparam int DEFAULT_RAM_DEPTH = 1024;
    typedef enum logic {GRANT_WR, GRANT_RD} grant_t;
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/bram_rsp_fifo.sv
// bram_rsp_fifo: synchronous response FIFO holding read data until the consumer takes it
//   clk, rst_n          : clock and synchronous active-low reset
//   push, push_data     : enqueue one word
//   pop, pop_data       : dequeue the head word; pop_data is the current head
//   count, empty, full  : occupancy status
module bram_rsp_fifo
    import bram_pkg::*;
#(
    parameter int WIDTH = DEFAULT_RAM_WIDTH,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNT_W'(DEPTH));
        do_pop   = pop && !empty;
        // a pop on the same edge frees the slot a full FIFO is pushing into
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        if (do_push) mem_d[wr_ptr_q] = push_data;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        pop_data = mem_q[rd_ptr_q];
        count    = count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/bram_port_controller.sv
// bram_port_controller: arbitrates write and read requests onto a single-port RAM with a credited response FIFO
//   clk, rst_n                          : clock and synchronous active-low reset
//   wr_valid/wr_ready, wr_addr, wr_data : write request handshake
//   rd_valid/rd_ready, rd_addr          : read request handshake
//   rsp_valid/rsp_ready, rsp_data       : read response handshake, in request order
//   ram_write_enable, ram_read_enable   : registered RAM strobes, never both high
//   ram_address, ram_data_in            : registered RAM address and write data
//   ram_data_out                        : registered RAM read data
module bram_port_controller
    import bram_pkg::*;
#(
    parameter int RAM_WIDTH = DEFAULT_RAM_WIDTH,
    parameter int RAM_DEPTH = DEFAULT_RAM_DEPTH,
    parameter int RSP_DEPTH = 4,
    localparam int ADDR_W = addr_w(RAM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [RAM_WIDTH-1:0] wr_data,
    input  logic                 rd_valid,
    output logic                 rd_ready,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [RAM_WIDTH-1:0] rsp_data,
    output logic                 ram_write_enable,
    output logic                 ram_read_enable,
    output logic [ADDR_W-1:0]    ram_address,
    output logic [RAM_WIDTH-1:0] ram_data_in,
    input  logic [RAM_WIDTH-1:0] ram_data_out
);
    localparam int CNT_W  = $clog2(RSP_DEPTH) + 1;
    localparam int CRED_W = CNT_W + 1;

    grant_t                last_winner_q, last_winner_d;
    logic                  ram_write_enable_q, ram_write_enable_d;
    logic                  ram_read_enable_q, ram_read_enable_d;
    logic [ADDR_W-1:0]     ram_address_q, ram_address_d;
    logic [RAM_WIDTH-1:0]  ram_data_in_q, ram_data_in_d;
    logic                  cap_pending_q, cap_pending_d;
    logic [CNT_W-1:0]      rsp_count;
    logic                  rsp_empty, rsp_full;
    logic [CRED_W-1:0]     credits;
    logic                  pop, rd_eligible, conflict, wr_fire, rd_fire;

    bram_rsp_fifo #(.WIDTH(RAM_WIDTH), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cap_pending_q),
        .push_data (ram_data_out),
        .pop       (pop),
        .pop_data  (rsp_data),
        .count     (rsp_count),
        .empty     (rsp_empty),
        .full      (rsp_full)
    );

    // Credits count every read still owed a FIFO slot: issued, being captured, or queued.
    // A same-cycle pop frees a slot, hence the intended rsp_ready -> rd_ready path.
    always_comb begin
        rsp_valid   = rst_n && !rsp_empty;
        pop         = rsp_valid && rsp_ready;
        credits     = CRED_W'(rsp_count) + CRED_W'(ram_read_enable_q)
                    + CRED_W'(cap_pending_q) - CRED_W'(pop);
        rd_eligible = !(rsp_full && !pop) && (credits < CRED_W'(RSP_DEPTH));
        conflict    = wr_valid && rd_valid && rd_eligible;
    end

    // Grant next-state: only a true conflict moves the fairness pointer.
    always_comb begin
        last_winner_d = conflict ? ((last_winner_q == GRANT_RD) ? GRANT_WR : GRANT_RD) : last_winner_q;
    end

    // Grant outputs: each ready looks only at the other side's valid.
    always_comb begin
        wr_ready = rst_n && !(rd_valid && rd_eligible && (last_winner_q == GRANT_WR));
        rd_ready = rst_n && rd_eligible && !(wr_valid && (last_winner_q == GRANT_RD));
        wr_fire  = wr_valid && wr_ready;
        rd_fire  = rd_valid && rd_ready;
    end

    always_comb begin
        ram_write_enable_d = wr_fire;
        ram_read_enable_d  = rd_fire;
        ram_address_d      = wr_fire ? wr_addr : (rd_fire ? rd_addr : ram_address_q);
        ram_data_in_d      = wr_fire ? wr_data : ram_data_in_q;
        cap_pending_d      = ram_read_enable_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_winner_q      <= GRANT_RD;
            ram_write_enable_q <= 1'b0;
            ram_read_enable_q  <= 1'b0;
            ram_address_q      <= '0;
            ram_data_in_q      <= '0;
            cap_pending_q      <= 1'b0;
        end else begin
            last_winner_q      <= last_winner_d;
            ram_write_enable_q <= ram_write_enable_d;
            ram_read_enable_q  <= ram_read_enable_d;
            ram_address_q      <= ram_address_d;
            ram_data_in_q      <= ram_data_in_d;
            cap_pending_q      <= cap_pending_d;
        end
    end

    always_comb begin
        ram_write_enable = ram_write_enable_q;
        ram_read_enable  = ram_read_enable_q;
        ram_address      = ram_address_q;
        ram_data_in      = ram_data_in_q;
    end
endmodule

// File: tb/tb_bram_port_controller.sv
// tb_bram_port_controller: randomized and directed checks of the BRAM port controller against a memory/queue model
module tb_bram_port_controller;
    localparam int W  = 16;
    localparam int D  = 1024;
    localparam int RD = 4;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0, rd_valid = 1'b0, rsp_ready = 1'b0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic          wr_ready, rd_ready, rsp_valid;
    logic [W-1:0]  rsp_data;
    logic          ram_write_enable, ram_read_enable;
    logic [AW-1:0] ram_address;
    logic [W-1:0]  ram_data_in;
    logic [W-1:0]  ram_data_out;

    always #5 clk = ~clk;

    bram_port_controller #(.RAM_WIDTH(W), .RAM_DEPTH(D), .RSP_DEPTH(RD)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .ram_write_enable(ram_write_enable), .ram_read_enable(ram_read_enable),
        .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    logic [W-1:0] ram [D];
    always @(posedge clk) begin
        if (ram_write_enable) ram[ram_address] <= ram_data_in;
        if (ram_read_enable) ram_data_out <= ram[ram_address];
    end

    logic [W-1:0] shadow [D];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int           got_cyc[$];
    int           cyc = 0;
    int           errors = 0;
    int           checks = 0;
    bit           wr_fire, rd_fire, pop_s, both_seen, dual_seen;

    task automatic step();
        @(negedge clk);
        wr_fire = wr_valid && wr_ready;
        rd_fire = rd_valid && rd_ready;
        pop_s   = rsp_valid && rsp_ready;
        if (ram_write_enable && ram_read_enable) both_seen = 1'b1;
        if (wr_fire && rd_fire) dual_seen = 1'b1;
        if (pop_s) begin
            got_q.push_back(rsp_data);
            got_cyc.push_back(cyc);
        end
        if (wr_fire) shadow[wr_addr] = wr_data;
        if (rd_fire) exp_q.push_back(shadow[rd_addr]);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic drain(input int budget, output bit ok);
        int n = 0;
        while (got_q.size() < exp_q.size() && n < budget) begin
            step();
            n++;
        end
        ok = (got_q.size() == exp_q.size());
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        clear_model();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_valid = 1'b1; rd_valid = 1'b1;
        wr_addr = AW'($urandom); rd_addr = AW'($urandom); wr_data = W'($urandom);
        step();
        step();
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
        checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL reset_rd_ready: got %b want 0", rd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if ({ram_write_enable, ram_read_enable} !== 2'b00) begin errors++; $display("FAIL reset_enables: got %b want 00", {ram_write_enable, ram_read_enable}); end
        checks++; if (ram_address !== '0 || ram_data_in !== '0) begin errors++; $display("FAIL reset_addr_data: got %h/%h want 0/0", ram_address, ram_data_in); end
        wr_valid = 1'b0; rd_valid = 1'b0; rst_n = 1'b1;
        clear_model();
        #1;
        checks++; if ({wr_ready, rd_ready} !== 2'b11) begin errors++; $display("FAIL release_ready: got %b want 11", {wr_ready, rd_ready}); end
    endtask

    task automatic test_single_write();
        bit ok;
        clear_model();
        wr_addr = 10'h005; wr_data = 16'hBEEF; wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        checks++; if (wr_fire !== 1'b1) begin errors++; $display("FAIL sw_accept: got %b want 1", wr_fire); end
        checks++; if ({ram_write_enable, ram_read_enable, ram_address, ram_data_in} !== {2'b10, 10'h005, 16'hBEEF}) begin
            errors++; $display("FAIL sw_issue: got we=%b re=%b a=%h d=%h want we=1 re=0 a=005 d=beef", ram_write_enable, ram_read_enable, ram_address, ram_data_in); end
        rd_addr = 10'h005; rd_valid = 1'b1;
        step();
        rd_valid = 1'b0;
        checks++; if (rd_fire !== 1'b1 || ram_read_enable !== 1'b1) begin errors++; $display("FAIL sr_accept: got fire=%b re=%b want 1/1", rd_fire, ram_read_enable); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL sr_lat1: got rsp_valid=%b want 0", rsp_valid); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL sr_lat2: got rsp_valid=%b want 0", rsp_valid); end
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'hBEEF) begin errors++; $display("FAIL sr_data: got v=%b d=%h want v=1 d=beef", rsp_valid, rsp_data); end
        rsp_ready = 1'b1;
        drain(4, ok);
        rsp_ready = 1'b0;
        checks++; if (!ok || got_q.size() != 1) begin errors++; $display("FAIL sr_pop: got %0d responses want 1", got_q.size()); end
        else if (got_q[0] !== 16'hBEEF) begin errors++; $display("FAIL sr_pop_data: got %h want beef", got_q[0]); end
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL sr_empty: got rsp_valid=%b want 0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n = 0, tries = 0;
        clear_model();
        for (int i = 0; i < 16; i++) begin
            wr_addr = AW'(i); wr_data = W'(16'h100 + i); wr_valid = 1'b1;
            step();
        end
        wr_valid = 1'b0;
        rsp_ready = 1'b1;
        while (n < 16 && tries < 40) begin
            rd_addr = AW'(n); rd_valid = 1'b1;
            step();
            tries++;
            if (rd_fire) n++;
        end
        rd_valid = 1'b0;
        checks++; if (tries != 16) begin errors++; $display("FAIL b2b_no_gaps: got %0d cycles want 16", tries); end
        drain(10, ok);
        checks++; if (!ok || got_q.size() != 16) begin errors++; $display("FAIL b2b_count: got %0d want 16", got_q.size()); end
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== W'(16'h100 + i)) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, got_q[i], W'(16'h100 + i)); end
        end
        if (got_cyc.size() == 16) begin
            checks++; if (got_cyc[15] - got_cyc[0] != 15) begin errors++; $display("FAIL b2b_rate: got span %0d want 15", got_cyc[15] - got_cyc[0]); end
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok;
        int acc = 0, n = 0;
        clear_model();
        rsp_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            rd_addr = AW'(acc); rd_valid = 1'b1;
            step();
            if (rd_fire) acc++;
        end
        checks++; if (acc != RD) begin errors++; $display("FAIL bp_accepted: got %0d want %0d", acc, RD); end
        checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL bp_rd_ready: got %b want 0", rd_ready); end
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h100) begin errors++; $display("FAIL bp_head: got v=%b d=%h want v=1 d=0100", rsp_valid, rsp_data); end
        rsp_ready = 1'b1;
        while ((acc < 8 || got_q.size() < exp_q.size()) && n < 60) begin
            rd_addr = AW'(acc); rd_valid = (acc < 8);
            step();
            if (rd_fire) acc++;
            n++;
        end
        rd_valid = 1'b0;
        drain(10, ok);
        checks++; if (acc != 8 || got_q.size() != 8) begin errors++; $display("FAIL bp_total: got acc=%0d rsp=%0d want 8/8", acc, got_q.size()); end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== W'(16'h100 + i)) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, got_q[i], W'(16'h100 + i)); end
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_conflict();
        bit ok;
        bit [5:0] wseq;
        int wi = 0, ri = 0;
        logic [W-1:0] wd [3];
        reset_dut();
        rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            wr_valid = 1'b1; rd_valid = 1'b1;
            wr_addr = AW'(10'h200 + wi); wr_data = W'($urandom); rd_addr = AW'(ri);
            if (wi < 3) wd[wi] = wr_data;
            step();
            wseq[c] = wr_fire;
            if (wr_fire) wi++;
            if (rd_fire) ri++;
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
        checks++; if (wseq !== 6'b010101) begin errors++; $display("FAIL conflict_order: got %b want 010101 (bit0=first grant, 1=write)", wseq); end
        checks++; if (wi != 3 || ri != 3) begin errors++; $display("FAIL conflict_count: got w=%0d r=%0d want 3/3", wi, ri); end
        drain(10, ok);
        checks++; if (!ok || got_q.size() != 3) begin errors++; $display("FAIL conflict_rsp: got %0d want 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== W'(16'h100 + i)) begin errors++; $display("FAIL conflict_rdata[%0d]: got %h want %h", i, got_q[i], W'(16'h100 + i)); end
        end
        for (int i = 0; i < 3 && i < wi; i++) begin
            checks++; if (ram[10'h200 + i] !== wd[i]) begin errors++; $display("FAIL conflict_wdata[%0d]: got %h want %h", i, ram[10'h200 + i], wd[i]); end
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_read_after_write();
        bit ok;
        reset_dut();
        wr_addr = 10'h3FF; wr_data = 16'h1234; rd_addr = 10'h3FF;
        wr_valid = 1'b1; rd_valid = 1'b1;
        step();
        checks++; if ({wr_fire, rd_fire} !== 2'b10) begin errors++; $display("FAIL raw_first: got w=%b r=%b want w=1 r=0", wr_fire, rd_fire); end
        wr_valid = 1'b0;
        step();
        checks++; if (rd_fire !== 1'b1) begin errors++; $display("FAIL raw_read1: got %b want 1", rd_fire); end
        step();
        checks++; if (rd_fire !== 1'b1) begin errors++; $display("FAIL raw_read2: got %b want 1", rd_fire); end
        rd_valid = 1'b0; rsp_ready = 1'b1;
        drain(10, ok);
        checks++; if (!ok || got_q.size() != 2) begin errors++; $display("FAIL raw_count: got %0d want 2", got_q.size()); end
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== 16'h1234) begin errors++; $display("FAIL raw_data[%0d]: got %h want 1234", i, got_q[i]); end
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        bit ok;
        int outstanding, bad = 0;
        bit pop_now, want_rd_ready;
        clear_model();
        both_seen = 1'b0; dual_seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            wr_valid = 1'($urandom); rd_valid = 1'($urandom);
            wr_addr = AW'($urandom_range(0, 63)); rd_addr = AW'($urandom_range(0, 63));
            wr_data = W'($urandom); rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            outstanding = exp_q.size() - got_q.size();
            pop_now = rsp_valid && rsp_ready;
            want_rd_ready = ((outstanding - int'(pop_now)) < RD);
            if (!wr_valid) begin
                checks++; if (rd_ready !== want_rd_ready) begin errors++; bad++;
                    if (bad < 5) $display("FAIL rand_credit: cycle %0d got rd_ready=%b want %b (outstanding=%0d)", c, rd_ready, want_rd_ready, outstanding); end
            end
            step();
        end
        wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
        drain(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rand_drain: got %0d responses want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (both_seen || dual_seen) begin errors++; $display("FAIL rand_exclusive: got both_enables=%b dual_accept=%b want 0/0", both_seen, dual_seen); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int acc = 0;
        logic [W-1:0] want2;
        clear_model();
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_addr = AW'(i); rd_valid = 1'b1;
            step();
            if (rd_fire) acc++;
        end
        rd_valid = 1'b0;
        checks++; if (acc != 4 || rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_setup: got acc=%0d v=%b want 4/1", acc, rsp_valid); end
        rst_n = 1'b0;
        step();
        checks++; if (rsp_valid !== 1'b0 || ram_read_enable !== 1'b0) begin errors++; $display("FAIL mid_reset: got v=%b re=%b want 0/0", rsp_valid, ram_read_enable); end
        rst_n = 1'b1;
        clear_model();
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mid_stale: got %0d responses want 0", got_q.size()); end
        want2 = shadow[2];
        rd_addr = 10'h002; rd_valid = 1'b1;
        step();
        rd_addr = 10'h3FF;
        step();
        rd_valid = 1'b0;
        drain(10, ok);
        checks++; if (!ok || got_q.size() != 2) begin errors++; $display("FAIL mid_reread: got %0d responses want 2", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== want2) begin errors++; $display("FAIL mid_data2: got %h want %h", got_q[0], want2); end
            checks++; if (got_q[1] !== 16'h1234) begin errors++; $display("FAIL mid_data3ff: got %h want 1234", got_q[1]); end
        end
        rsp_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < D; i++) begin
            ram[i] = '0;
            shadow[i] = '0;
        end
        ram_data_out = '0;
        both_seen = 1'b0;
        dual_seen = 1'b0;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_backpressure();
        checks++; if (both_seen || dual_seen) begin errors++; $display("FAIL exclusive: got both_enables=%b dual_accept=%b want 0/0", both_seen, dual_seen); end
        test_conflict();
        test_read_after_write();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bram_port_controller.md
# bram_port_controller

Initiator-side controller for the single-port block RAM. It accepts independent write and read requests over valid/ready handshakes and arbitrates them onto the RAM's single port, which takes a write enable, a read enable, an address and write data and returns registered read data. Returned read data goes through a small response FIFO, so a stalled response consumer never loses data. The block sits between the RAM and any client logic, such as a DMA engine or a test pattern generator.

## Interface
- RAM_WIDTH, 16, data word width; must match the attached RAM.
- RAM_DEPTH, 1024, number of words; address width is ADDR_W = $clog2(RAM_DEPTH).
- RSP_DEPTH, 4, response FIFO entries; power of two, at least 3.
- clk  input  1  single clock; all logic updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- wr_valid / wr_ready  input / output  1 / 1  write request handshake.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  RAM_WIDTH  write data.
- rd_valid / rd_ready  input / output  1 / 1  read request handshake.
- rd_addr  input  ADDR_W  read address.
- rsp_valid / rsp_ready  output / input  1 / 1  read response handshake.
- rsp_data  output  RAM_WIDTH  read response data.
- ram_write_enable, ram_read_enable  output  1  registered RAM strobes; never both high.
- ram_address  output  ADDR_W  registered RAM address.
- ram_data_in  output  RAM_WIDTH  registered RAM write data.
- ram_data_out  input  RAM_WIDTH  registered RAM read data.

## Operation
- **Transfers.**
  - A request transfers on any edge where its valid and ready are both high.
  - At most one request, read or write, is accepted per cycle.
- **Read credit.**
  - credits = reads issued to the RAM but not yet captured (0..2) + FIFO occupancy.
  - pop = rsp_valid & rsp_ready.
  - A read is eligible iff (credits − pop) < RSP_DEPTH.
  - This gives a deliberate combinational path from rsp_ready to rd_ready.
- **Arbitration.**
  - Write only valid: wr_ready=1.
  - Eligible read only valid: rd_ready=1.
  - Both valid and read eligible: grant the side that lost the previous conflict.
  - Both valid and read not eligible: write is granted; this does not count as a conflict.
  - A last_winner register changes only on a true conflict; its reset value is read, so the first conflict goes to write.
  - Ready never depends on the same side's valid. The loser's ready is low that cycle.
- **Issue stage.**
  - An accepted request is registered onto the ram_* outputs for exactly one cycle.
  - With no accepted request, both enables are 0; address and data hold their last values.
- **Capture stage.**
  - A cap_pending flag follows ram_read_enable by one cycle.
  - While cap_pending is set, ram_data_out is pushed into the FIFO on that edge.
  - Responses are returned strictly in request order.
- **Ordering.** A write accepted before a read to the same address is visible to that read, because the RAM executes operations in issue order.
- **Reset.**
  - rst_n=0 on any edge clears: FIFO, pointers, cap_pending, ram_write_enable, ram_read_enable, ram_address, ram_data_in, last_winner.
  - In-flight reads are dropped. RAM contents are untouched.
  - Output values during and after reset: wr_ready=0, rd_ready=0 and rsp_valid=0 while rst_n=0. On the first cycle after release, wr_ready=1 and rd_ready=1.

## Timing
- Write: accepted at edge E0 → ram_write_enable high in cycle E0..E1 → RAM written at E1.
- Read: accepted at E0 → ram_read_enable in cycle E0..E1 → ram_data_out valid after E1 → FIFO push at E2 → rsp_valid high after E2. Latency is 2 cycles, accept to response valid.
- Sustained reads with rsp_ready=1 run at 1 per cycle once RSP_DEPTH ≥ 3.
- FIFO push and pop on the same edge leave occupancy unchanged.
- rsp_data is the FIFO head. It is stable while rsp_valid=1 and rsp_ready=0.
- With rsp_ready held low, exactly RSP_DEPTH reads are accepted, then rd_ready=0.
- Writes continue during a read stall.

## Structure
- Package bram_pkg holds:
  - the ADDR_W helper;
  - typedef enum logic {GRANT_WR, GRANT_RD} grant_t;
  - the default RAM_WIDTH and RAM_DEPTH constants.
- Sub-module bram_rsp_fifo holds the response queue:
  - synchronous FIFO of RSP_DEPTH × RAM_WIDTH;
  - push, pop, count, empty and full outputs;
  - same-edge push/pop;
  - synchronous active-low reset.
- Top level contains the arbiter, issue registers, cap_pending and the credit logic.
- Bench pairs it with the single-port RAM model.

## Test plan
1. Reset then a single write: write addr 0x005 data 0xBEEF, then read 0x005 → rsp_data=0xBEEF exactly 2 cycles after read acceptance; the RAM never sees both enables high.
2. Back-to-back reads with rsp_ready=1: preload 0x000..0x00F with value = address + 0x100, issue 16 reads → 16 in-order responses 0x100..0x10F, one per cycle, no rd_ready gaps.
3. Backpressure: rsp_ready=0, 8 reads offered → exactly 4 accepted, then rd_ready=0; raise rsp_ready → 4 correct responses, then the remaining reads are accepted.
4. Conflict: wr_valid and rd_valid held high for 6 cycles → grants alternate W,R,W,R,W,R starting with write after reset; no request is dropped.
5. Read-after-write: write 0x3FF=0x1234 and a read of 0x3FF both valid in the same cycle, then a read of 0x3FF on the next cycle → the first read (granted after the write) returns 0x1234, as does the next.
6. Reset mid-operation: assert rst_n=0 with 2 reads in flight and 2 responses queued → rsp_valid=0 on the next cycle; after release no stale response appears; RAM data is intact on re-read.
